// File: rtl/fifo_avalon_st.sv
// Avalon-ST show-ahead FIFO with packet framing, fill level, threshold flags and sticky framing-error flag.
// Latency: a word written into an empty FIFO at edge N is presented on src_* after edge N+1; reads then stream one per cycle.
// Backpressure: snk_ready_o is a pure function of the registered fill level (low when DEPTH words are held or in reset).
module fifo_avalon_st #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int EMPTY_WIDTH         = 2,
  parameter int AWIDTH              = 4,
  parameter int ALMOST_FULL_LVL     = 12,
  parameter int ALMOST_EMPTY_LVL    = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data_i,
  input  logic                                          snk_valid_i,
  output logic                                          snk_ready_o,
  input  logic                                          snk_sop_i,
  input  logic                                          snk_eop_i,
  input  logic [EMPTY_WIDTH-1:0]                        snk_empty_i,
  output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data_o,
  output logic                                          src_valid_o,
  input  logic                                          src_ready_i,
  output logic                                          src_sop_o,
  output logic                                          src_eop_o,
  output logic [EMPTY_WIDTH-1:0]                        src_empty_o,
  output logic [AWIDTH:0]                               usedw_o,
  output logic                                          almost_full_o,
  output logic                                          almost_empty_o,
  output logic                                          frame_err_o
);

  localparam int WIDTH   = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int DEPTH   = 1 << AWIDTH;
  localparam int ENTRY_W = WIDTH + EMPTY_WIDTH + 2;
  localparam logic [AWIDTH:0] DEPTH_LVL = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF_LVL    = (AWIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [AWIDTH:0] AE_LVL    = (AWIDTH+1)'(ALMOST_EMPTY_LVL);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } frame_state_e;

  // Storage array; the output register holds one more word on top of it.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [AWIDTH:0]    wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]    rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]    usedw_q, usedw_d;
  logic               src_valid_q;
  logic [ENTRY_W-1:0] src_entry_q;
  frame_state_e       state_q;
  logic               frame_err_q;

  logic               snk_xfer;
  logic               src_xfer;
  logic               mem_empty;
  logic               out_load;
  logic [ENTRY_W-1:0] snk_entry;

  assign snk_ready_o = rst_n_i && (usedw_q < DEPTH_LVL);
  assign snk_xfer    = snk_valid_i && snk_ready_o;
  assign src_xfer    = src_valid_q && src_ready_i;
  assign mem_empty   = (wr_ptr_q == rd_ptr_q);
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign out_load    = !mem_empty && (!src_valid_q || src_ready_i);
  // Empty symbols are meaningful only on EOP beats; store zero otherwise.
  assign snk_entry   = {snk_sop_i, snk_eop_i,
                        (snk_eop_i ? snk_empty_i : {EMPTY_WIDTH{1'b0}}), snk_data_i};

  // Next-state for pointers and fill level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    if (snk_xfer) wr_ptr_d = wr_ptr_q + 1'b1;
    if (out_load) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({snk_xfer, src_xfer})
      2'b10:   usedw_d = usedw_q + 1'b1;
      2'b01:   usedw_d = usedw_q - 1'b1;
      default: usedw_d = usedw_q;
    endcase
  end

  // Pointer and fill-level registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (snk_xfer) mem_q[wr_ptr_q[AWIDTH-1:0]] <= snk_entry;
  end

  // Show-ahead output register: holds its word stable until accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      src_valid_q <= 1'b0;
      src_entry_q <= '0;
    end else if (out_load) begin
      src_valid_q <= 1'b1;
      src_entry_q <= mem_q[rd_ptr_q[AWIDTH-1:0]];
    end else if (src_xfer) begin
      src_valid_q <= 1'b0;
    end
  end

  // Sink framing checker; advances only on accepted beats, error flag is sticky.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      frame_err_q <= 1'b0;
    end else if (snk_xfer) begin
      case (state_q)
        S_IDLE: begin
          if (!snk_sop_i) frame_err_q <= 1'b1;
          else if (!snk_eop_i) state_q <= S_IN_PKT;
        end
        S_IN_PKT: begin
          if (snk_sop_i) frame_err_q <= 1'b1;
          if (snk_eop_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_valid_o    = src_valid_q;
  assign src_sop_o      = src_entry_q[ENTRY_W-1];
  assign src_eop_o      = src_entry_q[ENTRY_W-2];
  assign src_empty_o    = src_entry_q[WIDTH +: EMPTY_WIDTH];
  assign src_data_o     = src_entry_q[WIDTH-1:0];
  assign usedw_o        = usedw_q;
  assign almost_full_o  = (usedw_q >= AF_LVL);
  assign almost_empty_o = (usedw_q <= AE_LVL);
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_fifo_avalon_st.sv
// Directed bench for fifo_avalon_st with a scoreboard for the random stress phase.
module tb_fifo_avalon_st;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready, snk_sop, snk_eop;
  logic [1:0]  snk_empty;
  logic [31:0] src_data;
  logic        src_valid, src_ready, src_sop, src_eop;
  logic [1:0]  src_empty;
  logic [4:0]  usedw;
  logic        almost_full, almost_empty, frame_err;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic [35:0] sb_q[$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  always #5 clk = ~clk;

  fifo_avalon_st dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .snk_data_i     (snk_data),
    .snk_valid_i    (snk_valid),
    .snk_ready_o    (snk_ready),
    .snk_sop_i      (snk_sop),
    .snk_eop_i      (snk_eop),
    .snk_empty_i    (snk_empty),
    .src_data_o     (src_data),
    .src_valid_o    (src_valid),
    .src_ready_i    (src_ready),
    .src_sop_o      (src_sop),
    .src_eop_o      (src_eop),
    .src_empty_o    (src_empty),
    .usedw_o        (usedw),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .frame_err_o    (frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] em);
    snk_valid = v;
    snk_data  = d;
    snk_sop   = s;
    snk_eop   = e;
    snk_empty = em;
  endtask

  // Scoreboard: sample mid-cycle, transfers complete on the following rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("usedw_track", 64'(usedw), 64'(wr_cnt - rd_cnt));
      if (src_valid && src_ready) begin
        if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else chk("sb_data", 64'({src_sop, src_eop, src_empty, src_data}), 64'(sb_q.pop_front()));
        rd_cnt++;
      end
      if (snk_valid && snk_ready) begin
        sb_q.push_back({snk_sop, snk_eop, (snk_eop ? snk_empty : 2'b00), snk_data});
        wr_cnt++;
      end
    end
  end

  initial begin
    logic [31:0] exp_d;

    // Reset held with valid asserted
    rst_n = 1'b0; src_ready = 1'b0;
    drive(1'b1, 32'h11111111, 1'b1, 1'b1, 2'd0);
    repeat (3) tick();
    chk("rst_snk_ready", 64'(snk_ready), 64'(0));
    chk("rst_src_valid", 64'(src_valid), 64'(0));
    chk("rst_usedw", 64'(usedw), 64'(0));
    chk("rst_almost_empty", 64'(almost_empty), 64'(1));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_src_data", 64'(src_data), 64'(0));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_usedw", 64'(usedw), 64'(0));
    chk("post_rst_src_valid", 64'(src_valid), 64'(0));
    chk("post_rst_snk_ready", 64'(snk_ready), 64'(1));

    // Fill 16 words with output stalled
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b1, 2'd0);
      tick();
      chk("fill_usedw", 64'(usedw), 64'(i + 1));
      chk("fill_almost_full", 64'(almost_full), 64'((i + 1) >= 12));
    end
    chk("full_snk_ready", 64'(snk_ready), 64'(0));
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 2'd0);
    repeat (2) tick();
    chk("full_write_ignored", 64'(usedw), 64'(16));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Drain in order, one per cycle
    src_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 64'(src_valid), 64'(1));
      chk("drain_data", 64'(src_data), 64'(i));
      chk("drain_usedw", 64'(usedw), 64'(16 - i));
      chk("drain_almost_empty", 64'(almost_empty), 64'((16 - i) <= 2));
      tick();
    end
    chk("drained_usedw", 64'(usedw), 64'(0));
    chk("drained_valid", 64'(src_valid), 64'(0));
    src_ready = 1'b0;

    // Latency into empty FIFO, then hold under backpressure
    drive(1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 2'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    chk("lat_valid_n", 64'(src_valid), 64'(0));
    tick();
    chk("lat_valid_n1", 64'(src_valid), 64'(1));
    chk("lat_data_n1", 64'(src_data), 64'hA5A5A5A5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 64'(src_valid), 64'(1));
      chk("hold_data", 64'(src_data), 64'hA5A5A5A5);
    end

    // Simultaneous read and write at usedw=5
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 2'd0);
      tick();
    end
    chk("sim_pre_usedw", 64'(usedw), 64'(5));
    drive(1'b1, 32'h200, 1'b1, 1'b1, 2'd0);
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    chk("sim_rw_usedw", 64'(usedw), 64'(5));
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 1'b1, 1'b1, 2'd0);
      tick();
    end
    chk("sim_full_usedw", 64'(usedw), 64'(16));
    chk("sim_full_ready", 64'(snk_ready), 64'(0));
    drive(1'b1, 32'h400, 1'b1, 1'b1, 2'd0);
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    chk("full_rd_usedw", 64'(usedw), 64'(15));
    chk("full_rd_ready", 64'(snk_ready), 64'(1));
    src_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) exp_d = 32'h101 + 32'(i);
      else if (i == 3) exp_d = 32'h200;
      else exp_d = 32'h300 + 32'(i - 4);
      chk("sim_drain_valid", 64'(src_valid), 64'(1));
      chk("sim_drain_data", 64'(src_data), 64'(exp_d));
      tick();
    end
    src_ready = 1'b0;
    chk("sim_drain_usedw", 64'(usedw), 64'(0));

    // Packets: 3-beat then 1-beat
    drive(1'b1, 32'hAAAA0000, 1'b1, 1'b0, 2'd3); tick();
    drive(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 2'd1); tick();
    drive(1'b1, 32'hAAAA0002, 1'b0, 1'b1, 2'd2); tick();
    drive(1'b1, 32'hBBBB0000, 1'b1, 1'b1, 2'd3); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    chk("pkt_frame_err", 64'(frame_err), 64'(0));
    src_ready = 1'b1;
    chk("pkt_beat0", 64'({src_sop, src_eop, src_empty, src_data}), 64'h8_AAAA0000); tick();
    chk("pkt_beat1", 64'({src_sop, src_eop, src_empty, src_data}), 64'h0_AAAA0001); tick();
    chk("pkt_beat2", 64'({src_sop, src_eop, src_empty, src_data}), 64'h6_AAAA0002); tick();
    chk("pkt_beat3", 64'({src_sop, src_eop, src_empty, src_data}), 64'hF_BBBB0000); tick();
    src_ready = 1'b0;
    chk("pkt_frame_err_after", 64'(frame_err), 64'(0));

    // Beat without SOP while idle
    drive(1'b1, 32'hCCCC0000, 1'b0, 1'b0, 2'd2);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    chk("bad_frame_err", 64'(frame_err), 64'(1));
    tick();
    chk("bad_beat", 64'({src_valid, src_sop, src_eop, src_empty, src_data}), 64'h10_CCCC0000);
    chk("bad_frame_err_sticky", 64'(frame_err), 64'(1));
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    chk("bad_frame_err_sticky2", 64'(frame_err), 64'(1));
    chk("bad_usedw", 64'(usedw), 64'(0));

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0, 2'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_usedw", 64'(usedw), 64'(0));
    chk("mid_rst_valid", 64'(src_valid), 64'(0));
    chk("mid_rst_frame_err", 64'(frame_err), 64'(0));
    chk("mid_rst_ready", 64'(snk_ready), 64'(0));
    chk("mid_rst_src", 64'({src_sop, src_eop, src_empty, src_data}), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("mid_rst_no_survivor", 64'({src_valid, usedw}), 64'(0));

    // Random stress with scoreboard
    mon_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b1, 2'($urandom_range(0, 3)));
      src_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 2'd0);
    src_ready = 1'b1;
    repeat (40) tick();
    mon_en = 1'b0;
    chk("stress_sb_empty", 64'(sb_q.size()), 64'(0));
    chk("stress_usedw", 64'(usedw), 64'(0));
    chk("stress_frame_err", 64'(frame_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
